// File: rtl/uart_tx_fifo_if.sv
// Byte-write and serial-status bundle for the queued 8N1 UART transmitter.
interface uart_tx_fifo_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned COUNT_W = $clog2(FIFO_DEPTH) + 1;

    logic               tx_dv;
    logic [7:0]         tx_byte;
    logic               tx_ready;
    logic               tx_serial;
    logic               tx_active;
    logic               tx_done;
    logic [COUNT_W-1:0] fifo_count;

    // Producer side: queues bytes and watches line status
    modport master (
        output tx_dv, tx_byte,
        input  tx_ready, tx_serial, tx_active, tx_done, fifo_count
    );

    // Transmitter side
    modport slave (
        input  tx_dv, tx_byte,
        output tx_ready, tx_serial, tx_active, tx_done, fifo_count
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; frames go out back-to-back while data is queued.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_fifo_if.slave  bus
);
    localparam int unsigned CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned COUNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [COUNT_W-1:0] count_q;

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic             serial_q,  serial_d;
    logic             done_q,    done_d;
    logic             pop;
    logic             push;
    logic             last_clk;
    logic             not_empty;

    // Ready comes from the registered count, so a write while full is dropped even if a pop happens that edge
    assign bus.tx_ready   = (count_q < COUNT_W'(FIFO_DEPTH));
    assign push           = bus.tx_dv && bus.tx_ready;
    assign not_empty      = (count_q != '0);
    assign last_clk       = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign bus.fifo_count = count_q;
    assign bus.tx_serial  = serial_q;
    assign bus.tx_active  = (state_q != S_IDLE);
    assign bus.tx_done    = done_q;

    // FIFO storage; entries are only meaningful while counted, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.tx_byte;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + COUNT_W'(1);
                2'b01:   count_q <= count_q - COUNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Frame sequencing: next state, next line level and pop decision
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                serial_d  = 1'b1;
                clk_cnt_d = '0;
                if (not_empty) begin
                    pop      = 1'b1;
                    shift_d  = mem[rd_ptr];
                    serial_d = 1'b0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (last_clk) begin
                    clk_cnt_d = '0;
                    bit_idx_d = 3'd0;
                    serial_d  = shift_q[0];
                    state_d   = S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (last_clk) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        serial_d = 1'b1;
                        state_d  = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        serial_d  = shift_q[bit_idx_d];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (last_clk) begin
                    clk_cnt_d = '0;
                    if (not_empty) begin
                        // Chain straight into the next start bit with no idle cycle
                        pop      = 1'b1;
                        shift_d  = mem[rd_ptr];
                        serial_d = 1'b0;
                        state_d  = S_START;
                    end else begin
                        serial_d = 1'b1;
                        state_d  = S_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                    // Registered pulse lands on the final stop-bit cycle
                    done_d    = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 2));
                end
            end
            default: begin
                serial_d = 1'b1;
                state_d  = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops the line high at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            serial_q  <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus randomized loopback into an 8N1 receiver model.
module tb_uart_tx_fifo;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int rx_err    = 0;
    int act_cycles = 0;
    int act_runs  = 0;
    int done_cnt  = 0;
    int done_idle = 0;
    int peak      = 0;

    // Single comparison point for the whole bench
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected line level i cycles into a frame carrying byte b
    function automatic logic exp_line(input logic [7:0] b, input int i);
        int k;
        k = i / CPB;
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    // 8N1 receiver: samples mid-bit, pushes completed bytes, flags bad start/stop levels
    initial begin
        bit         busy = 1'b0;
        int         t = 0;
        int         k;
        logic [7:0] sh = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 1'b0;
            end else if (!busy) begin
                if (bus.tx_serial === 1'b0) begin
                    busy = 1'b1;
                    t = 0;
                end
            end else begin
                t++;
            end
            if (busy && !rst) begin
                if (t >= CPB/2 && ((t - CPB/2) % CPB) == 0) begin
                    k = (t - CPB/2) / CPB;
                    if (k == 0 && bus.tx_serial !== 1'b0) rx_err++;
                    if (k >= 1 && k <= 8) sh[k-1] = bus.tx_serial;
                    if (k == 9 && bus.tx_serial !== 1'b1) rx_err++;
                end
                if (t == 10*CPB - 1) begin
                    rx_q.push_back(sh);
                    busy = 1'b0;
                end
            end
        end
    end

    // Line activity statistics
    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.tx_active) act_cycles++;
                if (bus.tx_active && !prev) act_runs++;
                if (bus.tx_done) done_cnt++;
                if (bus.tx_done && !bus.tx_active) done_idle++;
                if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
            end
            prev = bus.tx_active;
        end
    end

    task automatic wait_idle(input int max);
        int n = 0;
        while ((bus.tx_active || bus.fifo_count != '0) && n < max) begin
            @(negedge clk);
            n++;
        end
        if (n >= max) check("idle_timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic drain_check(input string tag);
        check({tag, "_nrx"}, 32'(rx_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && rx_q.size() > 0)
            check(tag, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!bus.tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("ready_timeout", 1, 0);
        bus.tx_dv   = 1'b1;
        bus.tx_byte = b;
        exp_q.push_back(b);
        @(negedge clk);
        bus.tx_dv = 1'b0;
    endtask

    // Guard against a stuck run
    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, r0, d0, bad, gap;
        logic [7:0] burst [4];
        burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h55; burst[3] = 8'h81;

        rst         = 1'b1;
        bus.tx_dv   = 1'b0;
        bus.tx_byte = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_serial", 32'(bus.tx_serial), 1);
        check("rst_active", 32'(bus.tx_active), 0);
        check("rst_done",   32'(bus.tx_done),   0);
        check("rst_count",  32'(bus.fifo_count), 0);
        check("rst_ready",  32'(bus.tx_ready),  1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single frame 0xA5 checked cycle by cycle
        @(negedge clk);
        bus.tx_dv = 1'b1; bus.tx_byte = 8'hA5; exp_q.push_back(8'hA5);
        @(negedge clk);
        bus.tx_dv = 1'b0;
        check("t1_count", 32'(bus.fifo_count), 1);
        check("t1_pre_serial", 32'(bus.tx_serial), 1);
        bad = 0;
        for (int i = 0; i < 10*CPB; i++) begin
            @(negedge clk);
            if (bus.tx_serial !== exp_line(8'hA5, i)) bad++;
            if (bus.tx_active !== 1'b1) bad++;
            if (bus.tx_done !== (i == 10*CPB - 1)) bad++;
        end
        check("t1_wave", 32'(bad), 0);
        @(negedge clk);
        check("t1_post_active", 32'(bus.tx_active), 0);
        check("t1_post_serial", 32'(bus.tx_serial), 1);
        wait_idle(400);
        drain_check("t1_rx");

        // Burst of four on consecutive cycles
        a0 = act_cycles; r0 = act_runs; d0 = done_cnt;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("t2_ready", 32'(bus.tx_ready), 1);
            bus.tx_dv = 1'b1; bus.tx_byte = burst[j]; exp_q.push_back(burst[j]);
        end
        @(negedge clk);
        bus.tx_dv = 1'b0;
        wait_idle(2000);
        check("t2_active_cycles", 32'(act_cycles - a0), 640);
        check("t2_active_runs",   32'(act_runs - r0), 1);
        check("t2_done",          32'(done_cnt - d0), 4);
        drain_check("t2_rx");

        // Hold write valid for six cycles: the sixth finds the FIFO full
        a0 = act_cycles; r0 = act_runs; d0 = done_cnt; peak = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check("t3_ready", 32'(bus.tx_ready), (j < 5) ? 1 : 0);
            bus.tx_dv = 1'b1; bus.tx_byte = 8'(8'h10 + j);
            if (j < 5) exp_q.push_back(8'(8'h10 + j));
        end
        @(negedge clk);
        bus.tx_dv = 1'b0;
        wait_idle(2000);
        check("t3_done",   32'(done_cnt - d0), 5);
        check("t3_runs",   32'(act_runs - r0), 1);
        check("t3_cycles", 32'(act_cycles - a0), 800);
        check("t3_peak",   32'(peak), 4);
        drain_check("t3_rx");

        // Reset during data bit 3 with two bytes still queued
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            bus.tx_dv = 1'b1; bus.tx_byte = 8'(8'h11 * (j + 1));
        end
        @(negedge clk);
        bus.tx_dv = 1'b0;
        repeat (69) @(negedge clk);
        check("t4_count_pre",  32'(bus.fifo_count), 2);
        check("t4_active_pre", 32'(bus.tx_active), 1);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        check("t4_serial", 32'(bus.tx_serial), 1);
        check("t4_count",  32'(bus.fifo_count), 0);
        check("t4_active", 32'(bus.tx_active), 0);
        check("t4_ready",  32'(bus.tx_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (CPB * 12) @(negedge clk);
        check("t4_no_done", 32'(done_cnt - d0), 0);
        check("t4_quiet",   32'(bus.tx_active), 0);
        rx_q.delete();
        exp_q.delete();
        d0 = done_cnt;
        send(8'h3C);
        wait_idle(400);
        check("t4_done_after", 32'(done_cnt - d0), 1);
        drain_check("t4_rx");

        // Write on the same edge as a pop with two entries queued
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            bus.tx_dv = 1'b1; bus.tx_byte = 8'(8'hD0 + j); exp_q.push_back(8'(8'hD0 + j));
        end
        @(negedge clk);
        bus.tx_dv = 1'b0;
        repeat (10*CPB - 2) @(negedge clk);
        check("t6_count_pre", 32'(bus.fifo_count), 2);
        check("t6_done_pre",  32'(bus.tx_done), 1);
        bus.tx_dv = 1'b1; bus.tx_byte = 8'hD3; exp_q.push_back(8'hD3);
        @(negedge clk);
        bus.tx_dv = 1'b0;
        check("t6_count_post", 32'(bus.fifo_count), 2);
        check("t6_serial",     32'(bus.tx_serial), 0);
        check("t6_active",     32'(bus.tx_active), 1);
        wait_idle(2000);
        drain_check("t6_rx");

        // Randomized loopback of every byte value
        d0 = done_cnt;
        for (int b = 0; b < 256; b++) begin
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 200)) : 0;
            repeat (gap) @(negedge clk);
            send(8'(b));
        end
        wait_idle(4000);
        check("t5_done", 32'(done_cnt - d0), 256);
        drain_check("t5_rx");

        check("framing_errors", 32'(rx_err), 0);
        check("done_in_idle",   32'(done_idle), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
